// File: rtl/vx_axi_read_arb_n_if.sv
`default_nettype none
// ============================================================================
//  Module   : vx_axi_read_arb_n_if
//  Brief    : Bundle of NUM_PORTS AXI read (AR + R) channels. The "master"
//             modport drives AR and rready; the "slave" modport drives
//             arready and the R payload.
//  Revision : 1.0 - initial release
// ============================================================================
interface vx_axi_read_arb_n_if #(
    parameter int NUM_PORTS  = 1,
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 8
);
    // AR channel
    logic [NUM_PORTS-1:0]                 arvalid;
    logic [NUM_PORTS-1:0]                 arready;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] araddr;
    logic [NUM_PORTS-1:0][ID_WIDTH-1:0]   arid;
    logic [NUM_PORTS-1:0][7:0]            arlen;
    logic [NUM_PORTS-1:0][2:0]            arsize;
    logic [NUM_PORTS-1:0][1:0]            arburst;

    // R channel
    logic [NUM_PORTS-1:0]                 rvalid;
    logic [NUM_PORTS-1:0]                 rready;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata;
    logic [NUM_PORTS-1:0][ID_WIDTH-1:0]   rid;
    logic [NUM_PORTS-1:0]                 rlast;
    logic [NUM_PORTS-1:0][1:0]            rresp;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rid, rlast, rresp
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rid, rlast, rresp
    );
endinterface
`default_nettype wire

// File: rtl/vx_axi_read_arb_n.sv
`default_nettype none
// ============================================================================
//  Module   : vx_axi_read_arb_n
//  Brief    : N:1 AXI read arbiter. Round-robin AR arbitration into a
//             2-entry registered skid buffer, source index tagged into the
//             master ARID, per-input outstanding-burst limiting, and R beats
//             routed back by the tag carried in RID.
//  Config   : define VX_AXI_RD_ARB_PERF_EN to add the perf_ar_stalls and
//             perf_r_beats counter outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module vx_axi_read_arb_n #(
    parameter int NUM_INPUTS      = 4,
    parameter int AXI_DATA_WIDTH  = 512,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_TID_WIDTH   = 8,
    parameter int MAX_OUTSTANDING = 16,
    parameter int TAG_SEL_IDX     = 0
) (
    input  wire logic              clk,
    input  wire logic              reset,      // synchronous, active low
    vx_axi_read_arb_n_if.slave     s_axi,
    vx_axi_read_arb_n_if.master    m_axi,
    output logic                   rsp_err
`ifdef VX_AXI_RD_ARB_PERF_EN
    ,
    output logic [31:0]            perf_ar_stalls,
    output logic [31:0]            perf_r_beats
`endif
);

    localparam int SEL_BITS = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int MID_W    = AXI_TID_WIDTH + SEL_BITS;
    localparam int CNT_W    = 8;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [MID_W-1:0] LOW_MASK = (MID_W'(1) << TAG_SEL_IDX) - MID_W'(1);

    typedef struct packed {
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [MID_W-1:0]          id;
        logic [7:0]                len;
        logic [2:0]                size;
        logic [1:0]                burst;
    } ar_entry_t;

    // Insert the source index at TAG_SEL_IDX; ID bits above it move up.
    function automatic logic [MID_W-1:0] f_insert_sel(
        input logic [AXI_TID_WIDTH-1:0] id,
        input logic [SEL_BITS-1:0]      sel
    );
        logic [MID_W-1:0] id_ext;
        id_ext = MID_W'(id);
        return ((id_ext & ~LOW_MASK) << SEL_BITS)
             | (MID_W'(sel) << TAG_SEL_IDX)
             | (id_ext & LOW_MASK);
    endfunction

    // Remove the source index, restoring the original slave-side ID.
    function automatic logic [AXI_TID_WIDTH-1:0] f_strip_sel(
        input logic [MID_W-1:0] rid
    );
        logic [MID_W-1:0] id_ext;
        id_ext = (rid & LOW_MASK) | ((rid >> SEL_BITS) & ~LOW_MASK);
        return id_ext[AXI_TID_WIDTH-1:0];
    endfunction

    function automatic logic [SEL_BITS-1:0] f_get_sel(
        input logic [MID_W-1:0] rid
    );
        logic [MID_W-1:0] id_ext;
        id_ext = rid >> TAG_SEL_IDX;
        return id_ext[SEL_BITS-1:0];
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SEL_BITS-1:0]                  ptr_q, ptr_d;
    logic [1:0]                           skid_cnt_q, skid_cnt_d;
    ar_entry_t                            head_q, head_d;
    ar_entry_t                            tail_q, tail_d;
    logic [NUM_INPUTS-1:0][CNT_W-1:0]     cnt_q, cnt_d;
    logic                                 rsp_err_q, rsp_err_d;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [NUM_INPUTS-1:0]                w_eligible;
    logic [NUM_INPUTS-1:0]                w_grant;
    logic [SEL_BITS-1:0]                  w_grant_idx;
    logic                                 w_grant_vld;
    ar_entry_t                            w_new;
    logic                                 w_m_arvalid;
    logic                                 w_push;
    logic                                 w_pop;
    logic [SEL_BITS-1:0]                  w_rsel;
    logic [SEL_BITS-1:0]                  w_route;
    logic                                 w_sel_ok;
    logic [NUM_INPUTS-1:0]                w_s_rvalid;
    logic                                 w_m_rready;
    logic                                 w_r_hs;
    logic                                 w_err_set;

    // Round-robin pick among requesting inputs below their outstanding
    // limit; nothing is granted while in reset or while the skid is full.
    always_comb begin
        int idx;
        idx         = 0;
        w_eligible  = '0;
        w_grant     = '0;
        w_grant_idx = '0;
        w_grant_vld = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            w_eligible[i] = s_axi.arvalid[i] && (cnt_q[i] != MAX_CNT);
        end
        if (reset && (skid_cnt_q != 2'd2)) begin
            for (int k = 0; k < NUM_INPUTS; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= NUM_INPUTS) begin
                    idx = idx - NUM_INPUTS;
                end
                if (!w_grant_vld && w_eligible[idx]) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = SEL_BITS'(idx);
                end
            end
        end
        if (w_grant_vld) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end

    assign s_axi.arready = w_grant;

    // Payload of the granted input, tagged with its index.
    always_comb begin
        w_new.addr  = s_axi.araddr[w_grant_idx];
        w_new.id    = f_insert_sel(s_axi.arid[w_grant_idx], w_grant_idx);
        w_new.len   = s_axi.arlen[w_grant_idx];
        w_new.size  = s_axi.arsize[w_grant_idx];
        w_new.burst = s_axi.arburst[w_grant_idx];
    end

    // Next priority pointer: the input after the one just granted.
    always_comb begin
        ptr_d = ptr_q;
        if (w_grant_vld) begin
            if (int'(w_grant_idx) == NUM_INPUTS - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = w_grant_idx + SEL_BITS'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Two-entry skid buffer. Accept depends only on registered occupancy,
    // so m_axi.arready never reaches s_axi.arready combinationally.
    // ------------------------------------------------------------------
    assign w_m_arvalid = reset && (skid_cnt_q != 2'd0);
    assign w_push      = w_grant_vld;
    assign w_pop       = w_m_arvalid && m_axi.arready[0];

    // Skid buffer next state: head is always the oldest entry.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        skid_cnt_d = skid_cnt_q;
        case ({w_push, w_pop})
            2'b10: begin
                if (skid_cnt_q == 2'd0) begin
                    head_d = w_new;
                end else begin
                    tail_d = w_new;
                end
                skid_cnt_d = skid_cnt_q + 2'd1;
            end
            2'b01: begin
                head_d     = tail_q;
                skid_cnt_d = skid_cnt_q - 2'd1;
            end
            2'b11: begin
                if (skid_cnt_q == 2'd1) begin
                    head_d = w_new;
                end else begin
                    head_d = tail_q;
                    tail_d = w_new;
                end
            end
            default: begin
            end
        endcase
    end

    assign m_axi.arvalid[0] = w_m_arvalid;
    assign m_axi.araddr[0]  = head_q.addr;
    assign m_axi.arid[0]    = head_q.id;
    assign m_axi.arlen[0]   = head_q.len;
    assign m_axi.arsize[0]  = head_q.size;
    assign m_axi.arburst[0] = head_q.burst;

    // ------------------------------------------------------------------
    // R routing by the tag in RID. A single-input build ignores the tag.
    // ------------------------------------------------------------------
    assign w_rsel   = f_get_sel(m_axi.rid[0]);
    assign w_route  = (NUM_INPUTS == 1) ? '0 : w_rsel;
    assign w_sel_ok = (NUM_INPUTS == 1) || (int'(w_rsel) < NUM_INPUTS);

    // Steer rvalid to the tagged input and take its rready; beats with an
    // out-of-range tag are swallowed.
    always_comb begin
        w_s_rvalid = '0;
        w_m_rready = 1'b1;
        if (w_sel_ok) begin
            w_s_rvalid[w_route] = m_axi.rvalid[0];
            w_m_rready          = s_axi.rready[w_route];
        end
    end

    assign s_axi.rvalid    = w_s_rvalid;
    assign m_axi.rready[0] = w_m_rready;
    assign w_r_hs          = m_axi.rvalid[0] && w_m_rready;

    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_rpay
            assign s_axi.rdata[gi] = m_axi.rdata[0];
            assign s_axi.rid[gi]   = f_strip_sel(m_axi.rid[0]);
            assign s_axi.rlast[gi] = m_axi.rlast[0];
            assign s_axi.rresp[gi] = m_axi.rresp[0];
        end
    endgenerate

    // Outstanding counters: +1 on AR accept, -1 on a routed rlast, never
    // below zero.
    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            cnt_d[i] = cnt_q[i]
                     + CNT_W'(w_grant[i])
                     - CNT_W'(w_r_hs && m_axi.rlast[0] && w_sel_ok &&
                              (int'(w_route) == i) && (cnt_q[i] != '0));
        end
    end

    // Sticky error: bad tag, or rlast for an input with nothing in flight.
    always_comb begin
        w_err_set = w_r_hs &&
                    (!w_sel_ok || (m_axi.rlast[0] && (cnt_q[w_route] == '0)));
        rsp_err_d = rsp_err_q || w_err_set;
    end

    assign rsp_err = rsp_err_q;

    // State registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q      <= '0;
            skid_cnt_q <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            skid_cnt_q <= skid_cnt_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

`ifdef VX_AXI_RD_ARB_PERF_EN
    logic [31:0] perf_ar_stalls_q;
    logic [31:0] perf_r_beats_q;

    // Stall cycles (requests present, none granted) and master R beats.
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_ar_stalls_q <= '0;
            perf_r_beats_q   <= '0;
        end else begin
            if ((|s_axi.arvalid) && !w_grant_vld) begin
                perf_ar_stalls_q <= perf_ar_stalls_q + 32'd1;
            end
            if (w_r_hs) begin
                perf_r_beats_q <= perf_r_beats_q + 32'd1;
            end
        end
    end

    assign perf_ar_stalls = perf_ar_stalls_q;
    assign perf_r_beats   = perf_r_beats_q;
`endif

endmodule
`default_nettype wire

// File: doc/vx_axi_read_arb_n.md
VX_AXI_READ_ARB_N -- requirements
Module: VX_axi_read_arb_n

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 4, number of AXI read slave ports (1..16).
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 512, R data width.
REQ-003 SHALL have parameter AXI_ADDR_WIDTH, default 32, AR address width.
REQ-004 SHALL have parameter AXI_TID_WIDTH, default 8, slave-side ID width.
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 16, per-input outstanding burst limit (1..255).
REQ-006 SHALL have parameter TAG_SEL_IDX, default 0, bit position of the inserted select field in the master ID; SEL_BITS = max(1, clog2(NUM_INPUTS)).
REQ-007 SHALL have clk  input  1  single clock; all logic rising-edge.
REQ-008 SHALL have reset  input  1  synchronous, active-low reset (asserted when 0).
REQ-009 SHALL have s_axi_arvalid/arready  in/out  NUM_INPUTS  per-input AR handshake.
REQ-010 SHALL have s_axi_araddr/arid/arlen/arsize/arburst  input  NUM_INPUTS x (ADDR/TID/8/3/2)  per-input AR payload.
REQ-011 SHALL have s_axi_rvalid/rready  out/in  NUM_INPUTS  per-input R handshake.
REQ-012 SHALL have s_axi_rdata/rid/rlast/rresp  output  NUM_INPUTS x (DATA/TID/1/2)  per-input R payload.
REQ-013 SHALL have m_axi_ar*  master AR channel, same fields, m_axi_arid width AXI_TID_WIDTH+SEL_BITS.
REQ-014 SHALL have m_axi_r*  master R channel, same fields, m_axi_rid width AXI_TID_WIDTH+SEL_BITS.
REQ-015 SHALL have rsp_err  output  1  sticky flag: response with out-of-range select received.

Function
REQ-016 SHALL arbitrate AR requests round-robin, one grant per cycle; after granting input i, input i+1 (mod NUM_INPUTS) has highest priority.
REQ-017 SHALL register the master AR channel in a 2-entry skid buffer: 1-cycle latency, full throughput, no combinational arready path from m_axi_arready to s_axi_arready.
REQ-018 SHALL build m_axi_arid by inserting the granted index at bit TAG_SEL_IDX of s_axi_arid, higher ID bits shifted up by SEL_BITS.
REQ-019 SHALL keep per-input outstanding counter: +1 on input AR handshake, -1 on R handshake with rlast routed to that input; simultaneous inc/dec leaves it unchanged.
REQ-020 SHALL drive s_axi_arready[i]=0 and exclude input i from arbitration while its counter equals MAX_OUTSTANDING.
REQ-021 SHALL route R beats combinationally by m_axi_rid select field; s_axi_rvalid[sel]=m_axi_rvalid, m_axi_rready=s_axi_rready[sel], other inputs rvalid=0.
REQ-022 SHALL strip the select field from rid, restoring the original AXI_TID_WIDTH ID; rdata/rlast/rresp pass unchanged.
REQ-023 SHALL accept and discard a beat whose select >= NUM_INPUTS (m_axi_rready=1) and set rsp_err until reset.
REQ-024 SHALL, with NUM_INPUTS=1, insert a constant 0 select bit and route all responses to input 0.
REQ-025 SHALL never decrement a counter below 0; an rlast for an input with count 0 sets rsp_err.

Reset
REQ-026 SHALL, while reset=0, clear skid buffer, counters, RR pointer (input 0 highest priority) and rsp_err.
REQ-027 SHALL, while reset=0, hold m_axi_arvalid=0 and all s_axi_arready=0; first grant possible the cycle after reset returns to 1.
REQ-028 SHALL drop in-flight AR entries on mid-operation reset; subsequent R beats for dropped bursts are routed per REQ-021 and may set rsp_err per REQ-025.

Configuration
REQ-029 SHALL, when macro VX_AXI_RD_ARB_PERF_EN is defined, add outputs perf_ar_stalls[31:0] (cycles with any s_axi_arvalid high and no AR grant) and perf_r_beats[31:0] (master R handshakes), both reset to 0 and wrapping at 2^32.
REQ-030 SHALL, without VX_AXI_RD_ARB_PERF_EN, omit those ports and counters entirely; all other behaviour identical.

Verification
REQ-031 SHALL cover: NUM_INPUTS=4, all arvalid held high, m_axi_arready=1 -> grants 0,1,2,3,0 on consecutive cycles, m_axi_arid[1:0] matches index.
REQ-032 SHALL cover: MAX_OUTSTANDING=2, input 1 issues 2 bursts, no R -> s_axi_arready[1]=0; one rlast to input 1 -> arready[1]=1 next cycle.
REQ-033 SHALL cover: m_axi_rid=0x0B6 (sel=2, TID=0x2D), arlen=3 burst -> 4 beats on input 2 with rid=0x2D, counter 2 decrements only on beat 4.
REQ-034 SHALL cover: NUM_INPUTS=3, m_axi_rid select=3 -> beat accepted, no s_axi_rvalid, rsp_err=1 and stays 1.
REQ-035 SHALL cover: m_axi_arready=0 for 5 cycles, 3 inputs valid -> skid holds 2, no payload loss, perf_ar_stalls increments each stalled cycle (PERF_EN defined).
REQ-036 SHALL cover: reset=0 mid-burst for 1 cycle -> counters 0, m_axi_arvalid=0 next cycle, RR restarts at input 0.
